conv_window_ctrl: RTL and testbench

Sequencer for the line-buffered convolution front end. It accepts a raster pixel stream and forwards it into the `multi_delay_buffer` line store, configured with `Delay=ImageWidth` and `BufferCnt=KernelSize-1`. It tracks column and row position and gates the window-valid strobe during line-fill and column warm-up. It also applies downstream back-pressure and frames each image with start/done control.

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_window_ctrl_if.sv | 23 ++
 rtl/counter_roll.sv | 28 ++
 rtl/raster_counter.sv | 47 ++++
 rtl/conv_window_ctrl.sv | 106 ++++++++++
 tb/tb_conv_window_ctrl.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution front-end sequencer: FSM state encoding
// and the default window edge.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } conv_state_e;

    localparam int KERNEL_SIZE = 3;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel, line-buffer and window handshakes of conv_window_ctrl grouped as one bundle.
interface conv_window_ctrl_if;

    // Every pair is valid/ready: a transfer happens on a clock edge where both are
    // high; a valid, once raised, is held with its data stable until it transfers.
    logic pix_valid_i;
    logic pix_ready_o;
    logic buf_valid_o;
    logic buf_ready_i;
    logic win_valid_o;
    logic win_ready_i;

    modport master (
        output pix_valid_i, buf_ready_i, win_ready_i,
        input  pix_ready_o, buf_valid_o, win_valid_o
    );

    modport slave (
        input  pix_valid_i, buf_ready_i, win_ready_i,
        output pix_ready_o, buf_valid_o, win_valid_o
    );

endinterface

// File: rtl/counter_roll.sv
// Rolling up-counter: counts 0..Max on inc, then wraps to 0; clr has priority.
module counter_roll #(
    parameter int Width = 4,
    parameter int Max   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count,
    output logic             at_max
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    assign at_max = (count == MaxVal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + Width'(1);
        end
    end

endmodule

// File: rtl/raster_counter.sv
// Column/row position of the next pixel in raster order; both wrap to zero
// after the last pixel of the frame.
module raster_counter #(
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480,
    localparam int ColWidth   = $clog2(ImageWidth),
    localparam int RowWidth   = $clog2(ImageHeight)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [ColWidth-1:0] col,
    output logic [RowWidth-1:0] row,
    output logic                last_col,
    output logic                last_pix
);

    logic last_row;

    counter_roll #(
        .Width (ColWidth),
        .Max   (ImageWidth - 1)
    ) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (inc),
        .count  (col),
        .at_max (last_col)
    );

    counter_roll #(
        .Width (RowWidth),
        .Max   (ImageHeight - 1)
    ) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (inc & last_col),
        .count  (row),
        .at_max (last_row)
    );

    assign last_pix = last_col & last_row;

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer feeding a raster pixel stream into the line buffer and qualifying
// complete KernelSize x KernelSize windows at its registered output.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int  ImageWidth  = 640,
    parameter int  ImageHeight = 480,
    parameter int  KernelSize  = KERNEL_SIZE,
    localparam int ColWidth    = $clog2(ImageWidth),
    localparam int RowWidth    = $clog2(ImageHeight)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    output logic                busy_o,
    output logic [ColWidth-1:0] col_o,
    output logic [RowWidth-1:0] row_o,
    output logic                frame_done_o,
    output conv_state_e         state_o,
    conv_window_ctrl_if.slave   bus
);

    localparam logic [ColWidth-1:0] ColQual     = ColWidth'(KernelSize - 1);
    localparam logic [RowWidth-1:0] RowQual     = RowWidth'(KernelSize - 1);
    localparam logic [RowWidth-1:0] FillLastRow = RowWidth'(KernelSize - 2);

    conv_state_e         state_q, state_d;
    logic                win_valid_q, win_valid_d;
    logic                last_seen_q, last_seen_d;
    logic                accepting, win_stall, fire, qualify;
    logic                last_col, last_pix;
    logic [ColWidth-1:0] col;
    logic [RowWidth-1:0] row;

    // After the last pixel fires the counters are already back at zero, so
    // last_seen_q blocks further pixels until the final window is taken.
    assign accepting       = ((state_q == FILL) || (state_q == STREAM)) && !last_seen_q;
    assign win_stall       = win_valid_q && !bus.win_ready_i;
    assign bus.pix_ready_o = accepting && bus.buf_ready_i && !win_stall;
    assign fire            = bus.pix_valid_i && bus.pix_ready_o;
    assign bus.buf_valid_o = fire;
    assign qualify         = fire && (row >= RowQual) && (col >= ColQual);

    raster_counter #(
        .ImageWidth  (ImageWidth),
        .ImageHeight (ImageHeight)
    ) u_raster (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .clr      (state_q == IDLE),
        .inc      (fire),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    always_comb begin
        state_d     = state_q;
        last_seen_d = last_seen_q;
        // A qualifying fire wins over acceptance so windows can run back to back.
        win_valid_d = qualify ? 1'b1 : (bus.win_ready_i ? 1'b0 : win_valid_q);
        case (state_q)
            IDLE: begin
                if (start_i) state_d = FILL;
            end
            FILL: begin
                if (fire && last_col && (row == FillLastRow)) state_d = STREAM;
            end
            STREAM: begin
                if (fire && last_pix) begin
                    last_seen_d = 1'b1;
                end else if (last_seen_q && !win_stall) begin
                    last_seen_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign bus.win_valid_o = win_valid_q;
    assign busy_o          = (state_q != IDLE);
    assign frame_done_o    = (state_q == DONE);
    assign col_o           = col;
    assign row_o           = row;
    assign state_o         = state_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on an 8x4 image with a 3x3 window.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int K  = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  // clock / reset
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic busy_o, frame_done_o;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  conv_state_e state_o;

  always #5 clk = ~clk;

  conv_window_ctrl_if bus();

  conv_window_ctrl #(
    .ImageWidth  (W),
    .ImageHeight (H),
    .KernelSize  (K)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .frame_done_o (frame_done_o),
    .state_o      (state_o),
    .bus          (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // behavioural model: frame active, draining, done pulse, pixels accepted
  logic m_active = 1'b0;
  logic m_drain  = 1'b0;
  logic m_done   = 1'b0;
  logic m_win    = 1'b0;
  int   m_idx    = 0;
  logic [RW+CW-1:0] exp_q[$];

  int n_fire, n_acc, n_done, n_stall;
  int first_win_cyc, fire22_cyc, last_acc_cyc, done_cyc, last_fire_cyc;
  logic wrap_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard / compare process
  always @(negedge clk) begin : compare
    logic e_ready, e_fire, e_qual, old_win;
    int e_col, e_row;
    conv_state_e e_state;
    if (!rst_ni) begin
      m_active = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_win = 1'b0; m_idx = 0;
      exp_q.delete();
      wrap_pending = 1'b0;
    end
    e_col   = m_idx % W;
    e_row   = m_idx / W;
    e_ready = m_active && !m_drain && bus.buf_ready_i && !(m_win && !bus.win_ready_i);
    e_fire  = e_ready && bus.pix_valid_i;
    if (m_done)                          e_state = DONE;
    else if (!m_active)                  e_state = IDLE;
    else if (m_drain || e_row >= K - 1)  e_state = STREAM;
    else                                 e_state = FILL;

    chk("busy",       32'(busy_o),          32'(m_active || m_done));
    chk("pix_ready",  32'(bus.pix_ready_o), 32'(e_ready));
    chk("buf_valid",  32'(bus.buf_valid_o), 32'(e_fire));
    chk("buf_gate",   32'(bus.buf_valid_o & ~bus.buf_ready_i), 32'(0));
    chk("win_valid",  32'(bus.win_valid_o), 32'(m_win));
    chk("col",        32'(col_o),           e_col);
    chk("row",        32'(row_o),           e_row);
    chk("frame_done", 32'(frame_done_o),    32'(m_done));
    chk("state",      32'(state_o),         32'(e_state));

    if (rst_ni) begin
      if (wrap_pending) begin
        chk("wrap_col", 32'(col_o), 0);
        chk("wrap_row", 32'(row_o), 1);
        wrap_pending = 1'b0;
      end
      if (bus.buf_valid_o) begin
        n_fire++;
        last_fire_cyc = cyc;
        if (col_o == CW'(W - 1) && row_o == RW'(0)) wrap_pending = 1'b1;
        if (col_o == CW'(2) && row_o == RW'(2)) fire22_cyc = cyc;
      end
      if (bus.win_valid_o && first_win_cyc < 0) first_win_cyc = cyc;
      if (bus.win_valid_o && !bus.win_ready_i) n_stall++;
      if (bus.win_valid_o && bus.win_ready_i) begin
        n_acc++;
        last_acc_cyc = cyc;
        chk("win_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (frame_done_o) begin
        n_done++;
        done_cyc = cyc;
      end

      old_win = m_win;
      if (m_done) m_done = 1'b0;
      else if (!m_active) begin
        if (start_i) m_active = 1'b1;
      end else if (m_drain && (!old_win || bus.win_ready_i)) begin
        m_active = 1'b0; m_drain = 1'b0; m_done = 1'b1;
      end
      e_qual = e_fire && (e_col >= K - 1) && (e_row >= K - 1);
      if (e_qual) exp_q.push_back({RW'(e_row), CW'(e_col)});
      m_win = e_qual ? 1'b1 : (bus.win_ready_i ? 1'b0 : old_win);
      if (e_fire) begin
        m_idx++;
        if (m_idx == W * H) begin
          m_idx = 0;
          m_drain = 1'b1;
        end
      end
    end
  end

  task automatic clear_stats();
    n_fire = 0; n_acc = 0; n_done = 0; n_stall = 0;
    first_win_cyc = -1; fire22_cyc = -1; last_acc_cyc = -1; done_cyc = -1; last_fire_cyc = -1;
  endtask

  // driver: one frame, optional window back-pressure, line-buffer stall, or abort by reset
  task automatic run_frame(input bit bp, input bit stall, input int abort_at);
    int k, start_cyc, bp_left;
    clear_stats();
    bp_left = bp ? 5 : 0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    start_cyc = cyc;
    k = 0;
    bus.pix_valid_i = 1'b1;
    while (n_done == 0 && k < 400 && !(abort_at > 0 && n_fire >= abort_at)) begin
      start_i = (k == 20);
      bus.buf_ready_i = stall ? (k % 2 == 1) : 1'b1;
      if (bp_left > 0 && bus.win_valid_o) begin
        bus.win_ready_i = 1'b0;
        bp_left--;
      end else begin
        bus.win_ready_i = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    start_i = 1'b0;
    bus.buf_ready_i = 1'b1;
    bus.win_ready_i = 1'b1;
    chk("frame_timeout", 32'(k < 400), 1);
    if (abort_at > 0) begin
      chk("abort_fires", n_fire, abort_at);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_busy",       32'(busy_o),          0);
      chk("rst_pix_ready",  32'(bus.pix_ready_o), 0);
      chk("rst_buf_valid",  32'(bus.buf_valid_o), 0);
      chk("rst_win_valid",  32'(bus.win_valid_o), 0);
      chk("rst_frame_done", 32'(frame_done_o),    0);
      chk("rst_col",        32'(col_o),           0);
      chk("rst_row",        32'(row_o),           0);
      chk("rst_state",      32'(state_o),         32'(IDLE));
      bus.pix_valid_i = 1'b0;
      @(posedge clk); #1 rst_ni = 1'b1;
    end else begin
      bus.pix_valid_i = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
      end
      chk("fires",               n_fire, W * H);
      chk("windows",             n_acc, 12);
      chk("done_pulses",         n_done, 1);
      chk("done_after_last_win", done_cyc - last_acc_cyc, 1);
      chk("first_win_after_22",  first_win_cyc - fire22_cyc, 1);
      chk("exp_q_empty",         exp_q.size(), 0);
      if (!bp && !stall) begin
        chk("first_win_cycle", first_win_cyc - start_cyc, 19);
        chk("last_fire_cycle", last_fire_cyc - start_cyc, 31);
      end
      if (stall) chk("stall_frame_cycles", last_fire_cyc - start_cyc + 1, 64);
      if (bp)    chk("bp_stall_cycles", n_stall, 5);
    end
  endtask

  initial begin
    bus.pix_valid_i = 1'b0;
    bus.buf_ready_i = 1'b1;
    bus.win_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",       32'(busy_o),          0);
    chk("reset_pix_ready",  32'(bus.pix_ready_o), 0);
    chk("reset_buf_valid",  32'(bus.buf_valid_o), 0);
    chk("reset_win_valid",  32'(bus.win_valid_o), 0);
    chk("reset_frame_done", 32'(frame_done_o),    0);
    chk("reset_col",        32'(col_o),           0);
    chk("reset_row",        32'(row_o),           0);
    chk("reset_state",      32'(state_o),         32'(IDLE));
    rst_ni = 1'b1;

    // pixels offered while idle must be ignored
    bus.pix_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_pix_ready", 32'(bus.pix_ready_o), 0);
      chk("idle_buf_valid", 32'(bus.buf_valid_o), 0);
      chk("idle_col",       32'(col_o),           0);
      chk("idle_state",     32'(state_o),         32'(IDLE));
    end
    bus.pix_valid_i = 1'b0;

    run_frame(1'b0, 1'b0, 0);
    run_frame(1'b1, 1'b0, 0);
    run_frame(1'b0, 1'b1, 0);
    run_frame(1'b0, 1'b0, 17);
    run_frame(1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
